// File: rtl/fifo_drain_fsm.sv
// -----------------------------------------------------------------------------
// fifo_drain_fsm
//
// Read-side controller for the shared 8-bit FIFO. It starts reading once the
// FIFO holds START_LEVEL words and stops once it has drained to STOP_LEVEL, so
// the read side works in bursts rather than chasing every word. The FIFO has a
// one-cycle read latency. Each returning word lands in a 2-entry output
// buffer, which feeds a valid/ready downstream port.
//
// Optional build macro: FIFO_DRAIN_CHECK_EN
//   When defined, every landed word is compared against EXPECT_DATA. Mismatches
//   set a sticky data_err flag and bump a saturating err_count. When undefined,
//   both outputs are tied low and no compare logic exists.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   fifo_words  in   FIFO occupancy (CNT_W bits), updated on the rd_en edge
//   rd_en       out  FIFO read strobe; fifo_data is valid one cycle later
//   fifo_data   in   FIFO read data (DATA_W bits)
//   out_data    out  head of the output buffer (DATA_W bits)
//   out_valid   out  output buffer non-empty
//   out_ready   in   downstream accept; pop = out_valid && out_ready
//   reading     out  high while in the READING state
//   rd_total    out  count of landed words, wraps at 2^16
//   data_err    out  sticky data mismatch flag
//   err_count   out  saturating data mismatch count
// -----------------------------------------------------------------------------
module fifo_drain_fsm #(
  parameter int                DATA_W      = 8,
  parameter int                CNT_W       = 4,
  parameter int                START_LEVEL = 4,
  parameter int                STOP_LEVEL  = 1,
  parameter logic [DATA_W-1:0] EXPECT_DATA = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  fifo_words,
  output logic              rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reading,
  output logic [15:0]       rd_total,
  output logic              data_err,
  output logic [7:0]        err_count
);

  localparam logic [1:0] ST_STOPPED       = 2'd0;
  localparam logic [1:0] ST_WAIT_TO_START = 2'd1;
  localparam logic [1:0] ST_READING       = 2'd2;
  localparam logic [1:0] ST_WAIT_TO_STOP  = 2'd3;

  localparam logic [CNT_W-1:0] START_WORDS = CNT_W'(START_LEVEL);
  localparam logic [CNT_W-1:0] STOP_WORDS  = CNT_W'(STOP_LEVEL);

  logic [1:0]        state_reg, state_next;
  logic              inflight_reg;
  logic [1:0]        buf_count_reg, buf_count_next;
  logic [DATA_W-1:0] buf_reg  [2];
  logic [DATA_W-1:0] buf_next [2];
  logic [15:0]       rd_total_reg;

  logic       pop;
  logic       land;
  logic [2:0] pending;
  logic       can_issue;
  logic [1:0] wr_idx;

  assign out_valid = (buf_count_reg != 2'd0);
  assign pop       = out_valid && out_ready;
  assign land      = inflight_reg;

  // Words that will occupy the buffer after this edge if no new read is
  // issued: what is stored, plus the word already on its way, minus the pop.
  // A new read is only allowed if that still leaves room for its word.
  assign pending   = {1'b0, buf_count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign can_issue = (fifo_words != '0) && (pending < 3'd2);

  assign rd_en   = (state_reg == ST_READING) && can_issue;
  assign reading = (state_reg == ST_READING);

  // --------------------------------------------------------------------------
  // Start/stop hysteresis
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_STOPPED:       if (fifo_words >= START_WORDS) state_next = ST_WAIT_TO_START;
      ST_WAIT_TO_START: state_next = ST_READING;
      ST_READING:       if (fifo_words <= STOP_WORDS) state_next = ST_WAIT_TO_STOP;
      ST_WAIT_TO_STOP:  state_next = ST_STOPPED;
      default:          state_next = ST_STOPPED;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output buffer: slot 0 is always the head. A pop shifts slot 1 into slot 0.
  // A landing word goes to the first free slot after that shift, so when a
  // land and a pop happen together it lands behind the surviving entry, or at
  // the head if there was only one entry.
  // --------------------------------------------------------------------------
  assign wr_idx = buf_count_reg - {1'b0, pop};

  always_comb begin
    buf_count_next = buf_count_reg + {1'b0, land} - {1'b0, pop};
    for (int i = 0; i < 2; i++) begin
      buf_next[i] = pop ? buf_reg[1] : buf_reg[i];
      if (land && (wr_idx == 2'(i))) begin
        buf_next[i] = fifo_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_STOPPED;
      inflight_reg  <= 1'b0;
      buf_count_reg <= 2'd0;
      rd_total_reg  <= 16'd0;
      for (int i = 0; i < 2; i++) begin
        buf_reg[i] <= '0;
      end
    end else begin
      state_reg     <= state_next;
      inflight_reg  <= rd_en;
      buf_count_reg <= buf_count_next;
      for (int i = 0; i < 2; i++) begin
        buf_reg[i] <= buf_next[i];
      end
      if (land) begin
        rd_total_reg <= rd_total_reg + 16'd1;
      end
    end
  end

  assign out_data = buf_reg[0];
  assign rd_total = rd_total_reg;

  // --------------------------------------------------------------------------
  // Optional landed-data checker
  // --------------------------------------------------------------------------
`ifdef FIFO_DRAIN_CHECK_EN
  logic       data_err_reg;
  logic [7:0] err_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_err_reg  <= 1'b0;
      err_count_reg <= 8'd0;
    end else if (land && (fifo_data != EXPECT_DATA)) begin
      data_err_reg <= 1'b1;
      if (err_count_reg != 8'hFF) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign data_err  = data_err_reg;
  assign err_count = err_count_reg;
`else
  // The reference word only matters when the checker is built.
  logic unused_expect;
  assign unused_expect = ^EXPECT_DATA;

  assign data_err  = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_drain_fsm.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_fsm
//
// Bench for fifo_drain_fsm. A small FIFO model (queue) supplies fifo_words and
// fifo_data with one-cycle read latency. A scoreboard queue records the words
// handed out on each read and checks every downstream pop against it in order.
// A table drives the basic start/drain sequence cycle by cycle. Hand-written
// sequences cover backpressure, a forced-empty FIFO, reset during a read, and
// the optional data checker.
// -----------------------------------------------------------------------------
module tb_fifo_drain_fsm;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

`ifdef FIFO_DRAIN_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic              clk;
  logic              rst;
  logic [CNT_W-1:0]  fifo_words;
  logic              rd_en;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              reading;
  logic [15:0]       rd_total;
  logic              data_err;
  logic [7:0]        err_count;

  fifo_drain_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_words (fifo_words),
    .rd_en      (rd_en),
    .fifo_data  (fifo_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .reading    (reading),
    .rd_total   (rd_total),
    .data_err   (data_err),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks     = 0;
  int errors     = 0;
  int pops       = 0;
  int rd_pulses  = 0;
  bit force_zero = 1'b0;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];

  typedef struct packed {
    logic rdy;
    logic exp_rd;
    logic exp_reading;
    logic exp_valid;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic upd_words();
    int n;
    n = fifo_q.size();
    if (n > 15) n = 15;
    fifo_words = force_zero ? 4'd0 : 4'(n);
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    upd_words();
  endtask

  // Called at a negedge with inputs settled. Scores any pop and records any
  // read issued this cycle, then models the FIFO edge and returns at the next
  // negedge.
  task automatic tick();
    logic       rd_s;
    logic       pop_s;
    logic [7:0] od;
    rd_s  = rd_en;
    pop_s = out_valid && out_ready;
    od    = out_data;
    if (pop_s) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_order: got %0h expected no pop", od);
      end else begin
        chk("pop_order", {24'd0, od}, {24'd0, exp_q.pop_front()});
      end
    end
    if (rd_s) rd_pulses++;
    @(posedge clk);
    #1;
    if (rd_s) begin
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_on_empty: got rd_en=1 expected rd_en=0 with empty FIFO");
      end else begin
        fifo_data = fifo_q.pop_front();
        exp_q.push_back(fifo_data);
      end
    end
    upd_words();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
  endtask

  initial begin
    // Start/drain sequence from the cycle the FIFO reaches 4 words:
    // two cycles to reach READING, four reads, the landing cycle, and the
    // buffer emptying.
    //             rdy   rd    rdg   valid
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0};  // STOPPED, sees 4 words
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0};  // WAIT_TO_START
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0};  // first read (fw=4)
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};  // read (fw=3), word 0 in flight
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1};  // read (fw=2), word 0 at head
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1};  // last read (fw=1)
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1};  // WAIT_TO_STOP, last word lands
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1};  // STOPPED, last word at head
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0};  // buffer empty

    rst        = 1'b1;
    out_ready  = 1'b1;
    fifo_data  = 8'h00;
    fifo_words = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // ---- reset values ----
    chk("rst_rd_en",     {31'd0, rd_en},     32'd0);
    chk("rst_reading",   {31'd0, reading},   32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_rd_total",  {16'd0, rd_total},  32'd0);
    chk("rst_data_err",  {31'd0, data_err},  32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);

    // ---- below START_LEVEL: never starts ----
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("idle_rd_en",   {31'd0, rd_en},   32'd0);
      chk("idle_reading", {31'd0, reading}, 32'd0);
      tick();
    end

    // ---- table-driven start and drain ----
    push_word(8'h44);
    for (int i = 0; i < 9; i++) begin
      out_ready = tbl[i].rdy;
      #1;
      chk("tbl_rd_en",     {31'd0, rd_en},     {31'd0, tbl[i].exp_rd});
      chk("tbl_reading",   {31'd0, reading},   {31'd0, tbl[i].exp_reading});
      chk("tbl_out_valid", {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
      tick();
    end
    chk("drain_rd_total", {16'd0, rd_total}, 32'd4);
    chk("drain_pops",     pops,              32'd4);
    chk("drain_reads",    rd_pulses,         32'd4);
    chk("drain_exp_left", exp_q.size(),      32'd0);

    // ---- backpressure: buffer fills, reads stop at two ----
    begin
      int p0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push_word(8'h50 + 8'(i));
      p0 = rd_pulses;
      #1;
      for (int i = 0; i < 10; i++) tick();
      chk("bp_reads",     rd_pulses - p0,   32'd2);
      chk("bp_rd_en",     {31'd0, rd_en},   32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_reading",   {31'd0, reading}, 32'd1);
      chk("bp_head",      {24'd0, out_data}, 32'h50);
      for (int i = 0; i < 3; i++) tick();
      chk("bp_head_held", {24'd0, out_data}, 32'h50);
      chk("bp_rd_held",   {31'd0, rd_en},   32'd0);
      out_ready = 1'b1;
      #1;
      for (int i = 0; i < 20; i++) tick();
      chk("bp_rd_total",  {16'd0, rd_total}, 32'd12);
      chk("bp_pops",      pops,              32'd12);
      chk("bp_exp_left",  exp_q.size(),      32'd0);
      chk("bp_fifo_left", fifo_q.size(),     32'd0);
      chk("bp_out_valid_end", {31'd0, out_valid}, 32'd0);
    end

    // ---- FIFO forced empty while READING ----
    for (int i = 0; i < 5; i++) push_word(8'h60 + 8'(i));
    #1;
    tick();
    tick();
    force_zero = 1'b1;
    upd_words();
    #1;
    chk("empty_reading", {31'd0, reading}, 32'd1);
    chk("empty_rd_en",   {31'd0, rd_en},   32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("empty_rd_en_hold", {31'd0, rd_en}, 32'd0);
    end
    force_zero = 1'b0;
    upd_words();
    #1;
    for (int i = 0; i < 20; i++) tick();
    chk("empty_rd_total", {16'd0, rd_total}, 32'd17);
    chk("empty_exp_left", exp_q.size(),      32'd0);

    // ---- reset one cycle after a read: in-flight word is discarded ----
    for (int i = 0; i < 4; i++) push_word(8'h70 + 8'(i));
    #1;
    tick();
    tick();
    chk("mid_rd_en", {31'd0, rd_en}, 32'd1);
    tick();
    pulse_reset();
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rd_total",  {16'd0, rd_total},  32'd0);
    tick();
    chk("mid_out_valid_late", {31'd0, out_valid}, 32'd0);
    chk("mid_rd_total_late",  {16'd0, rd_total},  32'd0);
    chk("mid_out_data_late",  {24'd0, out_data},  32'd0);
    fifo_q.delete();
    upd_words();

    // ---- data checker: AA, 55, AA, AA ----
    pulse_reset();
    push_word(8'hAA);
    push_word(8'h55);
    push_word(8'hAA);
    push_word(8'hAA);
    #1;
    for (int i = 0; i < 4; i++) tick();
    chk("chk_err_before", {31'd0, data_err}, 32'd0);
    tick();
    chk("chk_err_after",  {31'd0, data_err}, EXP_ERR);
    for (int i = 0; i < 6; i++) tick();
    chk("chk_err_sticky", {31'd0, data_err},  EXP_ERR);
    chk("chk_err_count",  {24'd0, err_count}, EXP_ERR);
    chk("chk_rd_total",   {16'd0, rd_total},  32'd4);
    chk("chk_exp_left",   exp_q.size(),       32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
